seq_divider_32: RTL and testbench

Multi-cycle unsigned restoring divider for the RISC ALU's DIV/MOD operations.
- One quotient bit is produced per clock.
- Each trial subtraction is done as an addition: the inverted divisor plus a carry-in of 1, through a chain of 4-bit carry-lookahead groups.
- Uses a start/busy/done handshake with the control unit, which stalls the pipeline while busy=1.

---
 rtl/seq_divider_32.sv | 124 ++++++++++++
 tb/tb_seq_divider_32.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// The trial subtraction is an add of the inverted divisor through 4-bit CLA groups.
module seq_divider_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_work, r_work, div_reg;
    logic             accept;

    // Trial subtraction operands and CLA internals
    logic [WIDTH-1:0] sub_a, sub_b, diff;
    logic [3:0]       gg, gp, gc;
    logic             grp_g, grp_p, carry, sub_co;
    logic             fits;
    logic [WIDTH-1:0] r_next, q_next;

    // Low WIDTH bits of S = {R, Q msb}; S's top bit is R's msb.
    assign sub_a = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
    assign sub_b = ~div_reg;

    always_comb begin
        carry = 1'b1;
        diff  = '0;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        for (int gi = 0; gi < WIDTH / 4; gi++) begin
            gg    = sub_a[4*gi +: 4] & sub_b[4*gi +: 4];
            gp    = sub_a[4*gi +: 4] ^ sub_b[4*gi +: 4];
            gc[0] = carry;
            gc[1] = gg[0] | (gp[0] & gc[0]);
            gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
            gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & gc[0]);
            grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]);
            grp_p = &gp;
            diff[4*gi +: 4] = gp ^ gc;
            carry = grp_g | (grp_p & carry);
        end
        sub_co = carry;
    end

    // The divisor's top (WIDTH+1) bit inverts to 1, so the final carry is S[WIDTH] | low carry.
    assign fits   = r_work[WIDTH-1] | sub_co;
    assign r_next = fits ? diff : sub_a;
    assign q_next = {q_work[WIDTH-2:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN:     if (cnt == CNT_W'(1)) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            q_work      <= '0;
            r_work      <= '0;
            div_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end else begin
                q_work  <= dividend;
                r_work  <= '0;
                div_reg <= divisor;
                cnt     <= CNT_W'(WIDTH);
            end
        end else if (state == RUN) begin
            q_work <= q_next;
            r_work <= r_next;
            cnt    <= cnt - CNT_W'(1);
            // Visible results only move on the final iteration.
            if (cnt == CNT_W'(1)) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: vector table, random vectors and
// hand-written sequences for restart-ignore, back-to-back and async reset.
module tb_seq_divider_32;
    localparam int W = 32;

    logic         clk, rst, start;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         busy, done, div_by_zero;

    seq_divider_32 #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int total = 0;
    int bad   = 0;

    // scoreboard: {div_by_zero, quotient, remainder} plus expected done edge
    logic [2*W:0] exp_q[$];
    int           edge_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                logic [2*W:0] e;
                int           de;
                e  = exp_q.pop_front();
                de = edge_q.pop_front();
                chk("quotient", quotient, e[2*W-1:W]);
                chk("remainder", remainder, e[W-1:0]);
                chk("div_by_zero", div_by_zero, e[2*W]);
                chk("latency", edge_n, de);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // driver tasks
    task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
        logic [W-1:0] q_m, r_m;
        q_m = (dv == 0) ? '1 : dd / dv;
        r_m = (dv == 0) ? dd : dd % dv;
        exp_q.push_back({dv == 0, q_m, r_m});
        edge_q.push_back(edge_n + 1 + ((dv == 0) ? 0 : W));
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(output int busy_cnt);
        logic [W-1:0] hq, hr;
        int           held_bad;
        int           i;
        hq       = quotient;
        hr       = remainder;
        held_bad = 0;
        busy_cnt = 0;
        for (i = 0; i < 60; i++) begin
            if (done) break;
            if (busy) busy_cnt++;
            if (quotient !== hq || remainder !== hr) held_bad++;
            @(negedge clk);
        end
        if (i == 60) chk("done_timeout", 64'(i), 64'(0));
        chk("outputs_held_in_run", 64'(held_bad), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dcnt;
        logic [W-1:0] dd, dv;

        tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        tbl[2]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        tbl[3]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        tbl[4]  = '{32'h80000000,   32'h00010000,   32'h00008000,   32'd0,          1'b0};
        tbl[5]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        tbl[6]  = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
        tbl[7]  = '{32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
        tbl[8]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        tbl[9]  = '{32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0};
        tbl[10] = '{32'h12345678,   32'h10,         32'h01234567,   32'd8,          1'b0};
        tbl[11] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // table-driven vectors; constants are checked directly at done
        for (int i = 0; i < 12; i++) begin
            start = 1'b1; dividend = tbl[i].dd; divisor = tbl[i].dv;
            exp_q.push_back({tbl[i].dbz, tbl[i].q, tbl[i].r});
            edge_q.push_back(edge_n + 1 + (tbl[i].dbz ? 0 : W));
            @(negedge clk);
            start = 1'b0; dividend = $urandom; divisor = $urandom;
            wait_done(bc);
            chk("busy_cycles", 64'(bc), tbl[i].dbz ? 64'd0 : 64'(W));
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("result_held_q", quotient, tbl[i].q);
            chk("result_held_r", remainder, tbl[i].r);
        end

        // random vectors against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            dd = $urandom;
            dv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 255)) : $urandom;
            if (dv == 0) dv = 1;
            launch(dd, dv);
            wait_done(bc);
            chk("rand_busy_cycles", 64'(bc), 64'(W));
            @(negedge clk);
        end

        // start while busy is ignored
        launch(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        chk("ignored_q", quotient, 32'd333);
        @(negedge clk);

        // back-to-back: new start issued during the done cycle
        launch(32'd100, 32'd7);
        wait_done(bc);
        chk("b2b_first_done", done, 1);
        launch(32'd50, 32'd5);
        wait_done(bc);
        chk("b2b_busy_cycles", 64'(bc), 64'(W));
        chk("b2b_second_q", quotient, 32'd10);
        @(negedge clk);

        // async reset mid-run: outputs clear without a clock edge
        launch(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        exp_q.delete();
        edge_q.delete();
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_abort", 64'(dcnt), 64'd0);
        launch(32'd100, 32'd7);
        wait_done(bc);
        chk("post_reset_q", quotient, 32'd14);
        chk("post_reset_r", remainder, 32'd2);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
